// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on a single-outstanding req/ack bus,
// aligns/extends load data, and registers write-back results. Stalls upstream while busy.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        EX_Mem_wr_en,
    input  logic        EX_Mem_rd_en,
    input  logic [2:0]  EX_Mem_op,
    input  logic [31:0] EX_ALU_result,
    input  logic [31:0] EX_Rs2_data,
    input  logic        EX_MemToReg,
    input  logic        EX_RegFile_wr_en,
    input  logic [4:0]  EX_Rd_addr,
    output logic        DMem_req,
    output logic        DMem_we,
    output logic [31:0] DMem_addr,
    output logic [3:0]  DMem_be,
    output logic [31:0] DMem_wdata,
    input  logic        DMem_ack,
    input  logic [31:0] DMem_rdata,
    output logic        MEM_Stall,
    output logic        MEM_RegFile_wr_en,
    output logic        MEM_MemToReg,
    output logic [4:0]  MEM_Rd_addr,
    output logic [31:0] MEM_ALU_result,
    output logic [31:0] MEM_Load_data,
    output logic        MEM_Fault
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] wait_cnt;
    logic        is_acc, op_legal, misalign, bad_acc, timeout_hit;
    logic        stall, issue, done, abort, fault_nxt, wb_pass;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_acc      = EX_Mem_rd_en | EX_Mem_wr_en;
    assign op_legal    = EX_Mem_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign misalign    = ((EX_Mem_op[1:0] == 2'b01) & EX_ALU_result[0]) |
                         ((EX_Mem_op[1:0] == 2'b10) & (|EX_ALU_result[1:0]));
    assign bad_acc     = ~op_legal | misalign;
    assign timeout_hit = (TIMEOUT != 0) && ((wait_cnt + 32'd1) >= TIMEOUT);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        issue     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        fault_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (is_acc) begin
                    if (bad_acc) begin
                        fault_nxt = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        issue     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (DMem_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    fault_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stall must never leak out while the stage is held in reset.
    assign MEM_Stall = Reset_n & stall;
    assign wb_pass   = ((state == IDLE) & ~is_acc) | done;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = EX_Rs2_data;
        case (EX_Mem_op[1:0])
            2'b00: begin
                st_be    = 4'b0001 << EX_ALU_result[1:0];
                st_wdata = {4{EX_Rs2_data[7:0]}};
            end
            2'b01: begin
                st_be    = EX_ALU_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{EX_Rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = DMem_rdata[7:0];
        case (EX_ALU_result[1:0])
            2'b01:   ld_byte = DMem_rdata[15:8];
            2'b10:   ld_byte = DMem_rdata[23:16];
            2'b11:   ld_byte = DMem_rdata[31:24];
            default: ;
        endcase
        ld_half = EX_ALU_result[1] ? DMem_rdata[31:16] : DMem_rdata[15:0];
        case (EX_Mem_op)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = DMem_rdata;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            DMem_req          <= 1'b0;
            DMem_we           <= 1'b0;
            DMem_addr         <= '0;
            DMem_be           <= '0;
            DMem_wdata        <= '0;
            MEM_RegFile_wr_en <= 1'b0;
            MEM_MemToReg      <= 1'b0;
            MEM_Rd_addr       <= '0;
            MEM_ALU_result    <= '0;
            MEM_Load_data     <= '0;
            MEM_Fault         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue)
                wait_cnt <= '0;
            else if (state == BUSY && !DMem_ack)
                wait_cnt <= wait_cnt + 32'd1;
            if (issue) begin
                DMem_req   <= 1'b1;
                DMem_we    <= EX_Mem_wr_en;
                DMem_addr  <= {EX_ALU_result[31:2], 2'b00};
                DMem_be    <= EX_Mem_wr_en ? st_be : 4'b0000;
                DMem_wdata <= st_wdata;
            end else if (done | abort) begin
                DMem_req <= 1'b0;
            end
            MEM_RegFile_wr_en <= wb_pass & EX_RegFile_wr_en;
            MEM_MemToReg      <= wb_pass & EX_MemToReg;
            MEM_Rd_addr       <= EX_Rd_addr;
            MEM_ALU_result    <= EX_ALU_result;
            MEM_Load_data     <= (done & ~EX_Mem_wr_en) ? ld_data : 32'd0;
            MEM_Fault         <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction is driven and checked against
// a transaction-level model of the stage's rules (sizes, lanes, extension, timing).
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en;
    logic [2:0]  EX_Mem_op;
    logic [31:0] EX_ALU_result, EX_Rs2_data;
    logic [4:0]  EX_Rd_addr;
    logic        DMem_req, DMem_we, DMem_ack;
    logic [31:0] DMem_addr, DMem_wdata, DMem_rdata;
    logic [3:0]  DMem_be;
    logic        MEM_Stall, MEM_RegFile_wr_en, MEM_MemToReg, MEM_Fault;
    logic [4:0]  MEM_Rd_addr;
    logic [31:0] MEM_ALU_result, MEM_Load_data;

    int n_chk = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_op(EX_Mem_op),
        .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data), .EX_MemToReg(EX_MemToReg),
        .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
        .DMem_req(DMem_req), .DMem_we(DMem_we), .DMem_addr(DMem_addr), .DMem_be(DMem_be),
        .DMem_wdata(DMem_wdata), .DMem_ack(DMem_ack), .DMem_rdata(DMem_rdata),
        .MEM_Stall(MEM_Stall), .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_MemToReg(MEM_MemToReg),
        .MEM_Rd_addr(MEM_Rd_addr), .MEM_ALU_result(MEM_ALU_result), .MEM_Load_data(MEM_Load_data),
        .MEM_Fault(MEM_Fault)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned sz(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_bad(input logic [2:0] op, input logic [31:0] addr);
        bit legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
        return !legal || ((addr % sz(op)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
        logic [3:0] be = '0;
        int unsigned off = addr % 4;
        for (int unsigned i = 0; i < 4; i++)
            if (i >= off && i < off + sz(op)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] rs2);
        case (sz(op))
            1:       return (rs2 & 32'hFF) * 32'h0101_0101;
            2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (addr % 4));
        int unsigned bits = 8 * sz(op);
        if (bits < 32) begin
            v = v & ((32'd1 << bits) - 32'd1);
            if (!op[2] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        end
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_nop();
        EX_Mem_rd_en = 0; EX_Mem_wr_en = 0; EX_Mem_op = 0; EX_ALU_result = 0;
        EX_Rs2_data = 0; EX_MemToReg = 0; EX_RegFile_wr_en = 0; EX_Rd_addr = 0;
    endtask

    // Starts at posedge+1 of cycle 0, returns at posedge+1 of a fresh cycle.
    task automatic run_instr(input logic rd, input logic wr, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] rs2, input logic m2r,
                             input logic rfw, input logic [4:0] rda, input int nwait,
                             input logic [31:0] rdata);
        bit acc = rd | wr;
        EX_Mem_rd_en = rd; EX_Mem_wr_en = wr; EX_Mem_op = op; EX_ALU_result = addr;
        EX_Rs2_data = rs2; EX_MemToReg = m2r; EX_RegFile_wr_en = rfw; EX_Rd_addr = rda;
        DMem_ack = 0;
        @(negedge Clk);
        if (!acc) begin
            check("alu_stall", 32'(MEM_Stall), 0);
            tick(); drive_nop();
            @(negedge Clk);
            check("alu_wen", 32'(MEM_RegFile_wr_en), 32'(rfw));
            check("alu_m2r", 32'(MEM_MemToReg), 32'(m2r));
            check("alu_rd", 32'(MEM_Rd_addr), 32'(rda));
            check("alu_res", MEM_ALU_result, addr);
            check("alu_ld", MEM_Load_data, 0);
            check("alu_fault", 32'(MEM_Fault), 0);
        end else if (model_bad(op, addr)) begin
            check("bad_stall", 32'(MEM_Stall), 0);
            tick(); drive_nop();
            @(negedge Clk);
            check("bad_fault", 32'(MEM_Fault), 1);
            check("bad_req", 32'(DMem_req), 0);
            check("bad_wen", 32'(MEM_RegFile_wr_en), 0);
            check("bad_m2r", 32'(MEM_MemToReg), 0);
            tick();
            @(negedge Clk);
            check("bad_pulse", 32'(MEM_Fault), 0);
        end else begin
            check("acc_stall0", 32'(MEM_Stall), 1);
            check("acc_req0", 32'(DMem_req), 0);
            for (int k = 1; k <= nwait + 1; k++) begin
                tick();
                if (k == nwait + 1) begin DMem_ack = 1; DMem_rdata = rdata; end
                @(negedge Clk);
                check("acc_req", 32'(DMem_req), 1);
                check("acc_we", 32'(DMem_we), 32'(wr));
                check("acc_addr", DMem_addr, addr & ~32'd3);
                check("acc_be", 32'(DMem_be), wr ? 32'(model_be(op, addr)) : 0);
                if (wr) check("acc_wdata", DMem_wdata, model_wdata(op, rs2));
                check("acc_stall", 32'(MEM_Stall), (k <= nwait) ? 1 : 0);
                check("acc_wen_bub", 32'(MEM_RegFile_wr_en), 0);
            end
            tick(); DMem_ack = 0; drive_nop();
            @(negedge Clk);
            check("res_req", 32'(DMem_req), 0);
            check("res_wen", 32'(MEM_RegFile_wr_en), 32'(rfw));
            check("res_m2r", 32'(MEM_MemToReg), 32'(m2r));
            check("res_rd", 32'(MEM_Rd_addr), 32'(rda));
            check("res_alu", MEM_ALU_result, addr);
            check("res_ld", MEM_Load_data, wr ? 0 : model_load(op, addr, rdata));
            check("res_fault", 32'(MEM_Fault), 0);
        end
        tick();
    endtask

    initial begin
        int req_cycles;
        drive_nop();
        DMem_ack = 0; DMem_rdata = 0;
        #12;
        check("rst_req", 32'(DMem_req), 0);
        check("rst_stall", 32'(MEM_Stall), 0);
        check("rst_wen", 32'(MEM_RegFile_wr_en), 0);
        check("rst_ld", MEM_Load_data, 0);
        tick(); Reset_n = 1; tick();

        // directed cases
        run_instr(0, 0, 3'b000, 32'h1234, 0, 0, 1, 5, 0, 0);
        run_instr(1, 0, 3'b000, 32'h103, 0, 1, 1, 7, 0, 32'h80FF_0000);
        run_instr(1, 0, 3'b100, 32'h103, 0, 1, 1, 7, 0, 32'h80FF_0000);
        run_instr(0, 1, 3'b001, 32'h202, 32'hABCD_5678, 0, 0, 0, 3, 0);
        run_instr(1, 0, 3'b010, 32'h101, 0, 1, 1, 3, 0, 0);
        run_instr(1, 0, 3'b011, 32'h100, 0, 1, 1, 3, 0, 0);

        // timeout: no ack ever
        EX_Mem_rd_en = 1; EX_Mem_op = 3'b010; EX_ALU_result = 32'h40;
        EX_RegFile_wr_en = 1; EX_MemToReg = 1; EX_Rd_addr = 9;
        @(negedge Clk);
        check("to_stall0", 32'(MEM_Stall), 1);
        req_cycles = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 5) drive_nop();
            @(negedge Clk);
            if (DMem_req) req_cycles++;
            if (c < 4) check("to_stall", 32'(MEM_Stall), 1);
            if (c == 4) check("to_release", 32'(MEM_Stall), 0);
            if (c <= 4) check("to_nofault", 32'(MEM_Fault), 0);
            if (c == 5) begin
                check("to_fault", 32'(MEM_Fault), 1);
                check("to_wen", 32'(MEM_RegFile_wr_en), 0);
            end
            if (c == 6) check("to_pulse", 32'(MEM_Fault), 0);
        end
        check("to_req_cycles", 32'(req_cycles), 4);
        tick();

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            int kind = $urandom_range(0, 3);
            logic rd = 0, wr = 0;
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            case (kind)
                1: begin
                    rd = 1;
                    case ($urandom_range(0, 4))
                        0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2; 3: op = 3'd4; default: op = 3'd5;
                    endcase
                    addr = addr & ~(sz(op) - 1);
                end
                2: begin
                    wr = 1; rd = 1'($urandom_range(0, 1));
                    op = 3'($urandom_range(0, 2));
                    addr = addr & ~(sz(op) - 1);
                end
                3: begin
                    rd = 1; wr = 1'($urandom_range(0, 1));
                    if (wr) op = 3'($urandom_range(0, 2));
                end
                default: ;
            endcase
            run_instr(rd, wr, op, addr, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      $urandom_range(0, 3), $urandom);
        end

        // reset in the 2nd BUSY cycle, then a late ack
        EX_Mem_rd_en = 1; EX_Mem_op = 3'b010; EX_ALU_result = 32'h80;
        EX_RegFile_wr_en = 1; EX_MemToReg = 1; EX_Rd_addr = 4;
        @(negedge Clk);
        tick();
        @(negedge Clk);
        check("rb_req1", 32'(DMem_req), 1);
        tick();
        Reset_n = 0;
        #1;
        check("rb_req", 32'(DMem_req), 0);
        check("rb_stall", 32'(MEM_Stall), 0);
        check("rb_wen", 32'(MEM_RegFile_wr_en), 0);
        check("rb_alu", MEM_ALU_result, 0);
        check("rb_rd", 32'(MEM_Rd_addr), 0);
        check("rb_be", 32'(DMem_be), 0);
        drive_nop();
        tick();
        Reset_n = 1; DMem_ack = 1; DMem_rdata = 32'hDEAD_BEEF;
        @(negedge Clk);
        check("late_req", 32'(DMem_req), 0);
        check("late_stall", 32'(MEM_Stall), 0);
        tick(); DMem_ack = 0;
        @(negedge Clk);
        check("late_wen", 32'(MEM_RegFile_wr_en), 0);
        check("late_ld", MEM_Load_data, 0);
        check("late_req2", 32'(DMem_req), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
